// File: rtl/sort_job_scheduler.sv
// Round-robin front end that time-shares one sorter between M requesters and
// returns each sorted vector on a valid/ready response channel tagged with its requester ID.
module sort_job_scheduler #(
   parameter int unsigned M       = 4,
   parameter int unsigned N       = 6,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [M-1:0]                        req_valid,
   input  logic [M-1:0][N-1:0][WIDTH-1:0]      req_data,
   output logic [M-1:0]                        req_ready,
   output logic                                srt_start,
   output logic [N-1:0][WIDTH-1:0]             srt_data_in,
   input  logic                                srt_done,
   input  logic [N-1:0][WIDTH-1:0]             srt_data_sorted,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [$clog2(M)-1:0]                rsp_id,
   output logic [N-1:0][WIDTH-1:0]             rsp_data,
   output logic                                rsp_err,
   output logic                                busy,
   output logic [15:0]                         jobs_done
);

   localparam int unsigned ID_W  = $clog2(M);
   localparam int unsigned SUM_W = ID_W + 1;
   localparam int unsigned WD_W  = 8;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [ID_W-1:0]          rr_ptr;
   logic [ID_W-1:0]          grant_idx;
   logic                     grant_any;
   logic [N-1:0][WIDTH-1:0]  hold;
   logic [WD_W-1:0]          wd;
   logic                     wd_expired;

   assign wd_expired  = (wd == WD_W'(TIMEOUT - 1));
   assign srt_data_in = hold;

   // Rotating priority search starting at rr_ptr, wrapping at M.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic [ID_W-1:0]  sel;
      grant_any = 1'b0;
      grant_idx = '0;
      sum       = '0;
      sel       = '0;
      for (int i = 0; i < int'(M); i++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(i);
         if (sum >= SUM_W'(M)) begin
            sum = sum - SUM_W'(M);
         end
         sel = ID_W'(sum);
         if (!grant_any && req_valid[sel]) begin
            grant_any = 1'b1;
            grant_idx = sel;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (srt_done || wd_expired) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs: grant is offered only while idle.
   always_comb begin
      req_ready = '0;
      busy      = (state != IDLE);
      if (state == IDLE && grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Job datapath, watchdog and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         hold      <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         srt_start <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         jobs_done <= '0;
         wd        <= '0;
      end else begin
         srt_start <= (state_nxt == START);
         case (state)
            IDLE: begin
               if (grant_any) begin
                  hold   <= req_data[grant_idx];
                  rsp_id <= grant_idx;
               end
            end
            START: begin
               wd <= '0;
            end
            WAIT: begin
               wd <= wd + WD_W'(1);
               // A done arriving on the watchdog's last cycle still counts as success.
               if (srt_done) begin
                  rsp_data  <= srt_data_sorted;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
               end else if (wd_expired) begin
                  rsp_data  <= hold;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  jobs_done <= jobs_done + 16'd1;
                  rr_ptr    <= (rsp_id == ID_W'(M - 1)) ? '0 : rsp_id + ID_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
